// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed BCD adder sequencer (optional BCD_SERIAL_SUB_EN subtract mode)
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef BCD_SERIAL_SUB_EN
    input  logic                  sub,
`endif
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry_out,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDX_W-1:0] idx;
    logic             c;

    logic [W-1:0]     b_ld;
    logic             c_init;
    logic             any_bad;
    logic [3:0]       a_d;
    logic [3:0]       b_d;
    logic [4:0]       s;
    logic             c_nx;
    logic [3:0]       d_sum;
    logic             last;

    // err is judged on the operands as presented, before any complementing
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                any_bad = 1'b1;
            end
        end
    end

`ifdef BCD_SERIAL_SUB_EN
    always_comb begin
        b_ld   = b;
        c_init = 1'b0;
        if (sub) begin
            c_init = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                b_ld[4*i +: 4] = 4'd9 - b[4*i +: 4];
            end
        end
    end
`else
    assign b_ld   = b;
    assign c_init = 1'b0;
`endif

    always_comb begin
        a_d   = a_q[4*int'(idx) +: 4];
        b_d   = b_q[4*int'(idx) +: 4];
        s     = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c};
        c_nx  = (s > 5'd9);
        d_sum = c_nx ? (s[3:0] + 4'd6) : s[3:0];
        last  = (idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ADD;
            S_ADD:   if (last)  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state == S_ADD);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            c         <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b_ld;
                        sum <= '0;
                        c   <= c_init;
                        idx <= '0;
                        err <= any_bad;
                    end
                end
                S_ADD: begin
                    sum[4*int'(idx) +: 4] <= d_sum;
                    c <= c_nx;
                    if (last) begin
                        carry_out <= c_nx;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - randomized self-checking bench for bcd_serial_add_ctrl
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         err;
`ifdef BCD_SERIAL_SUB_EN
    logic         sub;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef BCD_SERIAL_SUB_EN
        .sub       (sub),
`endif
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_err(input logic [W-1:0] x, input logic [W-1:0] y);
        bit bad = 0;
        for (int i = 0; i < D; i++) begin
            if (x[4*i +: 4] > 9 || y[4*i +: 4] > 9) bad = 1;
        end
        return bad;
    endfunction

    // Valid operands: plain decimal arithmetic. Invalid digits: the defined per-digit +6 rule.
    function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y, input bit sb);
        logic [W:0]      r;
        longint unsigned xv, yv, m, tot;
        int              cc, t, yd;
        r = '0;
        if (!ref_err(x, y)) begin
            xv = 0; yv = 0; m = 1;
            for (int i = D - 1; i >= 0; i--) begin
                xv = xv * 10 + longint'(x[4*i +: 4]);
                yv = yv * 10 + longint'(y[4*i +: 4]);
                m  = m * 10;
            end
            tot  = sb ? (xv + (m - 1 - yv) + 1) : (xv + yv);
            r[W] = (tot >= m);
            tot  = tot % m;
            for (int i = 0; i < D; i++) begin
                r[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            cc = sb ? 1 : 0;
            for (int i = 0; i < D; i++) begin
                yd = sb ? ((9 - int'(y[4*i +: 4])) & 15) : int'(y[4*i +: 4]);
                t  = int'(x[4*i +: 4]) + yd + cc;
                if (t > 9) begin
                    r[4*i +: 4] = 4'(t + 6);
                    cc = 1;
                end else begin
                    r[4*i +: 4] = 4'(t);
                    cc = 0;
                end
            end
            r[W] = cc[0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit xs, input bit disturb);
        logic [W:0] exp_r;
        bit         exp_e;
        int         busy_n, done_n, done_at;
        exp_r = ref_result(xa, xb, xs);
        exp_e = ref_err(xa, xb);
        @(negedge clk);
        a = xa; b = xb; start = 1'b1;
`ifdef BCD_SERIAL_SUB_EN
        sub = xs;
`endif
        busy_n = 0; done_n = 0; done_at = -1;
        for (int k = 0; k < D + 3; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = k;
                    check("sum", 64'(sum), 64'(exp_r[W-1:0]));
                    check("carry_out", 64'(carry_out), 64'(exp_r[W]));
                    check("err", 64'(err), 64'(exp_e));
                end
            end
            start = (disturb && done_n == 0) ? 1'($urandom) : 1'b0;
            if (disturb) begin
                a = W'($urandom);
                b = W'($urandom);
`ifdef BCD_SERIAL_SUB_EN
                sub = 1'($urandom);
`endif
            end
        end
        start = 1'b0;
        check("busy_cycles", 64'(busy_n), 64'(D));
        check("done_pulses", 64'(done_n), 64'd1);
        check("done_latency", 64'(done_at), 64'(D));
        check("sum_hold", 64'(sum), 64'(exp_r[W-1:0]));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
`ifdef BCD_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_carry", 64'(carry_out), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset = 1'b0;

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0958, 16'h0047, 1'b0, 1'b0);
        run_op(16'h00A0, 16'h0001, 1'b0, 1'b0);
        run_op(16'h00FF, 16'h00FF, 1'b0, 1'b0);
        run_op(16'h4321, 16'h1111, 1'b0, 1'b1);

        // reset on the second ADD cycle discards the partial result
        @(negedge clk);
        a = 16'h111A; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        start = 1'b1;
        @(negedge clk);
        check("rst_start_busy", 64'(busy), 64'd0);
        reset = 1'b0; start = 1'b0;
        run_op(16'h0505, 16'h0505, 1'b0, 1'b0);

`ifdef BCD_SERIAL_SUB_EN
        run_op(16'h0050, 16'h0023, 1'b1, 1'b0);
        run_op(16'h0023, 16'h0050, 1'b1, 1'b0);
`endif

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra, rb;
            bit rs;
            ra = ($urandom_range(0, 3) == 0) ? W'($urandom) : rand_bcd();
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom) : rand_bcd();
`ifdef BCD_SERIAL_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
